// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, with start/busy/done
// handshake. Subtraction is A + ~B + ~Cin, so Cout=1 means "no borrow".
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             sum_bit, carry_next, last_bit, accept;

  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign res_next   = {sum_bit, res_sr};
  assign last_bit   = (state == RUN) && (count == LAST);
  assign accept     = (state == IDLE) && start;
  assign busy       = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results only move on the completion edge, so S/Cout/ovf never expose partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      S      <= '0;
      Cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        a_sr  <= A;
        b_sr  <= mode ? ~B : B;
        carry <= mode ? ~Cin : Cin;
        count <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= carry_next;
        res_sr <= res_next[WIDTH-1:1];
        count  <= count + CW'(1);
        if (last_bit) begin
          S    <= res_next;
          Cout <= carry_next;
          ovf  <= carry ^ carry_next;
        end
      end
    end
  end

endmodule
